// File: rtl/hexdump_ctrl_if.sv
// hexdump_ctrl_if: handshake bundle between the word producer, the hex dump
// sequencer and the downstream char sink.
//   in_data / in_data_valid / in_eol / out_data_ready : upstream word handshake
//   out_char / out_char_valid / in_char_ready         : downstream char handshake
//   out_busy                                          : sequencer not in IDLE
// Modports: master drives the upstream word and the sink ready (producer/sink
// side); slave is the sequencer itself.
interface hexdump_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CHAR_SIZE  = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_data_valid;
    logic                  in_eol;
    logic                  out_data_ready;
    logic [CHAR_SIZE-1:0]  out_char;
    logic                  out_char_valid;
    logic                  in_char_ready;
    logic                  out_busy;

    modport master (
        output in_data, in_data_valid, in_eol, in_char_ready,
        input  out_data_ready, out_char, out_char_valid, out_busy
    );

    modport slave (
        input  in_data, in_data_valid, in_eol, in_char_ready,
        output out_data_ready, out_char, out_char_valid, out_busy
    );
endinterface

// File: rtl/hexdump_ctrl.sv
// hexdump_ctrl: turns binary words into a lowercase ASCII hex dump, one char
// per cycle, MS nibble first. After each word it emits SEP_CHAR, or CR LF when
// the word closes a line (WORDS_PER_LINE words, or in_eol sampled with it).
//   in_clk : clock, rising edge
//   in_rst : synchronous active-high reset
//   bus    : hexdump_ctrl_if.slave (word in, char out, busy)
// All outputs are registered; they are computed from the next state.
module hexdump_ctrl #(
    parameter int          DATA_WIDTH     = 16,
    parameter int          CHAR_SIZE      = 8,
    parameter int          DIGIT_SIZE     = 4,
    parameter int          WORDS_PER_LINE = 8,
    parameter logic [7:0]  SEP_CHAR       = 8'h20
) (
    input  logic           in_clk,
    input  logic           in_rst,
    hexdump_ctrl_if.slave  bus
);
    localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_SIZE;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W      = $clog2(WORDS_PER_LINE) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {IDLE, DIGIT, SEP, CR, LF} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  eol_q, eol_d;
    logic [CHAR_SIZE-1:0]  char_q, char_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;

    logic                  xfer;
    logic [DATA_WIDTH-1:0] shifted;
    logic [3:0]            nib;
    logic [7:0]            hex;

    assign xfer = valid_q & bus.in_char_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        eol_d   = eol_q;
        unique case (state_q)
            IDLE: begin
                // ready_q is only high in IDLE, so it doubles as the state gate
                if (bus.in_data_valid && ready_q) begin
                    data_d  = bus.in_data;
                    eol_d   = bus.in_eol;
                    idx_d   = '0;
                    state_d = DIGIT;
                end
            end
            DIGIT: begin
                if (xfer) begin
                    if (idx_q != LAST_IDX)
                        idx_d = idx_q + 1'b1;
                    else if (eol_q || cnt_q == LAST_WORD)
                        state_d = CR;
                    else
                        state_d = SEP;
                end
            end
            SEP: begin
                if (xfer) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            CR: begin
                if (xfer) state_d = LF;
            end
            LF: begin
                if (xfer) begin
                    cnt_d   = '0;
                    eol_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single nibble->hex path: shift the selected nibble to the top and convert.
    always_comb begin
        shifted = data_d << (idx_d * DIGIT_SIZE);
        nib     = shifted[DATA_WIDTH-1 -: 4];
        if (nib < 4'd10) hex = 8'h30 + {4'b0, nib};
        else             hex = 8'h57 + {4'b0, nib};   // 8'h57 + 10 = 'a'
    end

    always_comb begin
        valid_d = (state_d != IDLE);
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        unique case (state_d)
            DIGIT:   char_d = CHAR_SIZE'(hex);
            SEP:     char_d = CHAR_SIZE'(SEP_CHAR);
            CR:      char_d = CHAR_SIZE'(8'h0d);
            LF:      char_d = CHAR_SIZE'(8'h0a);
            default: char_d = '0;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            eol_q   <= 1'b0;
            char_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            eol_q   <= eol_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.out_char       = char_q;
    assign bus.out_char_valid = valid_q;
    assign bus.out_data_ready = ready_q;
    assign bus.out_busy       = busy_q;
endmodule
